// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared register-number constants, legal write range and writeback entry types.
// Pure declarations; no latency or backpressure of its own.
// Imported by the writeback controller, its interface and its bench.
package regfile_wb_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t ZERO = 5'd0;
  localparam reg_addr_t T0   = 5'd8;
  localparam reg_addr_t S0   = 5'd16;
  localparam reg_addr_t T8   = 5'd24;
  localparam reg_addr_t T9   = 5'd25;

  localparam reg_addr_t LEGAL_LO = T0;
  localparam reg_addr_t LEGAL_HI = T9;

  // One bit per register inside LEGAL_LO..LEGAL_HI.
  localparam logic [31:0] LEGAL_MASK = 32'h03FF_FF00;

  localparam int DATA_W = 32;

  typedef struct packed {
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic logic is_legal(input reg_addr_t a);
    return (a >= LEGAL_LO) && (a <= LEGAL_HI);
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback bundle: ALU result, load-result handshake, issue tag and register-file write port.
// Wires only; timing is set by the controller on the slave side.
// Only the load path backpressures, through mem_valid/mem_ready.
interface regfile_wb_ctrl_if;
  import regfile_wb_ctrl_pkg::*;

  logic              alu_valid;
  reg_addr_t         alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  reg_addr_t         mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              issue_valid;
  reg_addr_t         issue_addr;
  logic              reg_write_en;
  reg_addr_t         write_address;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       busy;
  logic [7:0]        drop_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr,
    input  mem_ready, reg_write_en, write_address, write_data, busy, drop_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr,
    output mem_ready, reg_write_en, write_address, write_data, busy, drop_count
  );

endinterface

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO holding pending load results.
// Head is visible combinationally; a push becomes visible the cycle after it is written.
// Push is honoured when not full or when a pop frees a slot in the same cycle.
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback arbiter: ALU first, queued loads second, with busy scoreboard and drop counter.
// One cycle from selection to a registered write strobe; illegal destinations are dropped and counted.
// ALU never stalls; loads are backpressured by mem_ready when the queue is full and not draining.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int MEM_Q_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wb_ctrl_if.slave bus
);

  wb_entry_t         mem_entry;
  wb_entry_t         head;
  logic              q_full;
  logic              q_empty;
  logic              deq;
  logic              enq;
  logic              alu_drop;
  logic              mem_drop;
  logic              sel_en;
  reg_addr_t         sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic [31:0]       busy_set;
  logic [31:0]       busy_clr;

  logic              write_en_q;
  reg_addr_t         write_addr_q;
  logic [DATA_W-1:0] write_data_q;
  logic [31:0]       busy_q;
  logic [7:0]        drop_q;

  assign deq           = !bus.alu_valid && !q_empty;
  assign bus.mem_ready = !q_full || deq;
  assign enq           = bus.mem_valid && bus.mem_ready;
  assign mem_entry     = '{addr: bus.mem_addr, data: bus.mem_data};

  wb_sync_fifo #(
    .DEPTH (MEM_Q_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_load_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .push_data (mem_entry),
    .pop       (deq),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // At most one source is selected per cycle; both drop terms are summed regardless.
  assign sel_addr = bus.alu_valid ? bus.alu_addr : head.addr;
  assign sel_data = bus.alu_valid ? bus.alu_data : head.data;
  assign alu_drop = bus.alu_valid && !is_legal(bus.alu_addr);
  assign mem_drop = deq && !is_legal(head.addr);
  assign sel_en   = (bus.alu_valid || deq) && is_legal(sel_addr);

  assign drop_inc = {1'b0, alu_drop} + {1'b0, mem_drop};
  assign drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};

  assign busy_clr = sel_en ? (32'b1 << sel_addr) : '0;
  assign busy_set = (bus.issue_valid && is_legal(bus.issue_addr)) ? (32'b1 << bus.issue_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_q   <= 1'b0;
      write_addr_q <= ZERO;
      write_data_q <= '0;
      busy_q       <= '0;
      drop_q       <= '0;
    end else begin
      write_en_q <= sel_en;
      if (sel_en) begin
        write_addr_q <= sel_addr;
        write_data_q <= sel_data;
      end
      // A set on the same edge as a clear wins.
      busy_q <= ((busy_q & ~busy_clr) | busy_set) & LEGAL_MASK;
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign bus.reg_write_en  = write_en_q;
  assign bus.write_address = write_addr_q;
  assign bus.write_data    = write_data_q;
  assign bus.busy          = busy_q;
  assign bus.drop_count    = drop_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized and directed bench for regfile_wb_ctrl against a queue-based reference model.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus();

  regfile_wb_ctrl #(.MEM_Q_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] q[$];
  logic [31:0] busy_m;
  int          drop_m;
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  function automatic bit legal_m(input int a);
    return (a >= 8) && (a <= 25);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy_m = '0;
    drop_m = 0;
    exp_we = 1'b0;
  endtask

  task automatic drive(input bit av, input int aa, input logic [31:0] ad,
                       input bit mv, input int ma, input logic [31:0] md,
                       input bit iv, input int ia);
    bus.alu_valid   = av;
    bus.alu_addr    = 5'(aa);
    bus.alu_data    = ad;
    bus.mem_valid   = mv;
    bus.mem_addr    = 5'(ma);
    bus.mem_data    = md;
    bus.issue_valid = iv;
    bus.issue_addr  = 5'(ia);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  task automatic step();
    bit          deq;
    bit          exp_rdy;
    bit          have;
    logic [4:0]  a;
    logic [31:0] d;
    logic [36:0] e;
    #1;
    deq     = !bus.alu_valid && (q.size() > 0);
    exp_rdy = (q.size() < DEPTH) || deq;
    check("mem_ready", 32'(bus.mem_ready), 32'(exp_rdy));
    @(posedge clk);
    have = 1'b0;
    a = '0;
    d = '0;
    if (bus.alu_valid) begin
      have = 1'b1; a = bus.alu_addr; d = bus.alu_data;
    end else if (deq) begin
      e = q.pop_front();
      have = 1'b1; a = e[36:32]; d = e[31:0];
    end
    exp_we = have && legal_m(int'(a));
    if (have && !legal_m(int'(a))) drop_m = (drop_m + 1 > 255) ? 255 : drop_m + 1;
    if (exp_we) begin
      exp_wa = a;
      exp_wd = d;
      busy_m[a] = 1'b0;
    end
    if (bus.issue_valid && legal_m(int'(bus.issue_addr))) busy_m[bus.issue_addr] = 1'b1;
    if (bus.mem_valid && exp_rdy) q.push_back({bus.mem_addr, bus.mem_data});
    #1;
    check("reg_write_en", 32'(bus.reg_write_en), 32'(exp_we));
    if (exp_we) begin
      check("write_address", 32'(bus.write_address), 32'(exp_wa));
      check("write_data", bus.write_data, exp_wd);
    end
    check("busy", bus.busy, busy_m);
    check("drop_count", 32'(bus.drop_count), 32'(drop_m));
  endtask

  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 32'h0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'h1);
    check("rst_write_en", 32'(bus.reg_write_en), 32'h0);
    check("rst_write_address", 32'(bus.write_address), 32'h0);
    check("rst_write_data", bus.write_data, 32'h0);
    check("rst_drop_count", 32'(bus.drop_count), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 3) != 0) ? int'($urandom_range(8, 25)) : int'($urandom_range(0, 31));
  endfunction

  function automatic int illegal_addr();
    int v;
    v = int'($urandom_range(0, 13));
    return (v < 8) ? v : v + 18;
  endfunction

  initial begin
    int p_alu;
    int p_mem;
    int p_iss;

    pulse_reset();

    // Single ALU write, visible for exactly one cycle.
    drive(1, 9, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();
    check("alu_we", 32'(bus.reg_write_en), 32'h1);
    check("alu_addr9", 32'(bus.write_address), 32'd9);
    check("alu_dead", bus.write_data, 32'hDEADBEEF);
    idle();
    step();
    check("alu_we_gone", 32'(bus.reg_write_en), 32'h0);

    // ALU beats a load arriving in the same cycle.
    drive(1, 11, 32'h1111, 1, 10, 32'h1010, 0, 0);
    step();
    check("prio_first", 32'(bus.write_address), 32'd11);
    idle();
    step();
    check("prio_second", 32'(bus.write_address), 32'd10);
    check("prio_second_data", bus.write_data, 32'h1010);

    // Queue fills under continuous ALU traffic, then drains in order.
    drive(1, 9, 32'h1, 1, 16, 32'h16, 0, 0);
    step();
    drive(1, 9, 32'h2, 1, 17, 32'h17, 0, 0);
    step();
    drive(1, 9, 32'h3, 1, 18, 32'h18, 0, 0);
    #1;
    check("full_not_ready", 32'(bus.mem_ready), 32'h0);
    step();
    drive(0, 0, 0, 1, 18, 32'h18, 0, 0);
    #1;
    check("full_deq_ready", 32'(bus.mem_ready), 32'h1);
    step();
    check("drain_16", 32'(bus.write_address), 32'd16);
    idle();
    step();
    check("drain_17", 32'(bus.write_address), 32'd17);
    step();
    check("drain_18", 32'(bus.write_address), 32'd18);
    step();
    check("drain_done", 32'(bus.reg_write_en), 32'h0);

    // Issue and write collide on the same edge: busy stays set.
    drive(0, 0, 0, 0, 0, 0, 1, 20);
    step();
    check("busy20_set", 32'(bus.busy[20]), 32'h1);
    drive(1, 20, 32'h20, 0, 0, 0, 1, 20);
    step();
    check("busy20_hold", 32'(bus.busy[20]), 32'h1);
    drive(1, 20, 32'h21, 0, 0, 0, 0, 0);
    step();
    check("busy20_clear", 32'(bus.busy[20]), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    step();
    check("busy_illegal_issue", bus.busy, 32'h0);

    // Illegal writes from both sources, then saturation.
    drive(1, 0, 32'h5, 0, 0, 0, 0, 0);
    step();
    check("drop_1", 32'(bus.drop_count), 32'd1);
    drive(0, 0, 0, 1, 30, 32'h30, 0, 0);
    step();
    idle();
    step();
    check("drop_2", 32'(bus.drop_count), 32'd2);
    check("drop_2_no_we", 32'(bus.reg_write_en), 32'h0);
    for (int i = 0; i < 300; i++) begin
      drive(1, illegal_addr(), $urandom, 0, 0, 0, 0, 0);
      step();
      check("drop_sat", 32'(bus.drop_count), 32'((3 + i > 255) ? 255 : 3 + i));
      check("drop_no_we", 32'(bus.reg_write_en), 32'h0);
    end

    // Reset between edges discards queued loads and busy bits.
    drive(1, 9, 32'h9, 1, 12, 32'h12, 1, 12);
    step();
    drive(1, 9, 32'h9, 1, 13, 32'h13, 1, 13);
    step();
    check("pre_rst_busy", bus.busy & 32'h0000_3000, 32'h0000_3000);
    @(negedge clk);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      step();
      check("post_rst_no_we", 32'(bus.reg_write_en), 32'h0);
    end

    // Randomized traffic across several load/ALU mixes.
    for (int seg = 0; seg < 4; seg++) begin
      p_alu = (seg == 0) ? 20 : (seg == 1) ? 50 : (seg == 2) ? 80 : 95;
      p_mem = (seg == 3) ? 90 : 60;
      p_iss = 40;
      for (int c = 0; c < 1000; c++) begin
        drive(($urandom_range(0, 99) < p_alu), rand_addr(), $urandom,
              ($urandom_range(0, 99) < p_mem), rand_addr(), $urandom,
              ($urandom_range(0, 99) < p_iss), rand_addr());
        step();
      end
      pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
